// File: rtl/audio_sample_dac_if.sv
// Sample-source link: the DAC pulses sample_req to advance the source and
// reads its current offset-binary sample.
interface audio_sample_dac_if;
  logic        sample_req;
  logic [15:0] sample_in;

  modport master (output sample_req, input  sample_in);
  modport slave  (input  sample_req, output sample_in);
endinterface

// File: rtl/audio_sample_dac.sv
// Sample-rate divider, volume/mute/ramp level control and first-order
// sigma-delta modulator driving a 1-bit audio pin.
module audio_sample_dac #(
  parameter int unsigned DIV       = 1250,
  parameter logic [15:0] RAMP_STEP = 16'h0040
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      mute,
  input  logic [2:0]                volume,
  audio_sample_dac_if.master        src,
  output logic                      audio_out,
  output logic                      busy
);

  typedef enum logic [1:0] {OFF, RAMP_UP, RUN, RAMP_DOWN} state_t;

  state_t      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [15:0] level_q, level_d;
  logic [16:0] acc_q, acc_d;
  logic        req_q, req_d;
  logic        aout_q, aout_d;

  logic               tick;
  logic [16:0]        up_sum;
  logic signed [15:0] s_smp, a_smp;
  logic [15:0]        att;

  assign tick   = (div_q == 16'(DIV - 1));
  assign up_sum = {1'b0, level_q} + {1'b0, RAMP_STEP};

  // Offset binary -> two's complement, shift, and back; only consumed on a tick.
  assign s_smp = signed'(src.sample_in ^ 16'h8000);
  assign a_smp = s_smp >>> volume;
  assign att   = a_smp ^ 16'h8000;

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    case (state_q)
      OFF: begin
        level_d = 16'h0000;
        if (enable) state_d = RAMP_UP;
      end
      RAMP_UP: begin
        if (tick) level_d = (up_sum > 17'h08000) ? 16'h8000 : up_sum[15:0];
        if (!enable)                  state_d = RAMP_DOWN;
        else if (level_q == 16'h8000) state_d = RUN;
      end
      RUN: begin
        if (tick) level_d = mute ? 16'h8000 : att;
        if (!enable) state_d = RAMP_DOWN;
      end
      RAMP_DOWN: begin
        if (tick) level_d = (level_q > RAMP_STEP) ? level_q - RAMP_STEP : 16'h0000;
        if (enable)                   state_d = RAMP_UP;
        else if (level_q == 16'h0000) state_d = OFF;
      end
      default: state_d = OFF;
    endcase
  end

  always_comb begin
    div_d  = tick ? 16'h0000 : div_q + 16'h0001;
    req_d  = tick && (state_q != OFF);
    acc_d  = {1'b0, acc_q[15:0]} + {1'b0, level_q};
    aout_d = acc_d[16];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= OFF;
      div_q   <= '0;
      level_q <= '0;
      acc_q   <= '0;
      req_q   <= 1'b0;
      aout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      level_q <= level_d;
      acc_q   <= acc_d;
      req_q   <= req_d;
      aout_q  <= aout_d;
    end
  end

  assign src.sample_req = req_q;
  assign audio_out      = aout_q;
  assign busy           = (state_q != OFF);

endmodule

// File: tb/tb_audio_sample_dac.sv
// Randomized bench for audio_sample_dac against a cycle-level arithmetic model
// of the level/ramp rules and the sigma-delta carry stream.
module tb_audio_sample_dac;
  localparam int DIV  = 8;
  localparam int STEP = 'h2000;
  localparam int S_OFF = 0, S_UP = 1, S_RUN = 2, S_DN = 3;

  logic       clk, rst, enable, mute;
  logic [2:0] volume;
  logic       audio_out, busy;

  audio_sample_dac_if intf ();

  audio_sample_dac #(.DIV(DIV), .RAMP_STEP(16'(STEP))) dut (
    .clk(clk), .rst(rst), .enable(enable), .mute(mute), .volume(volume),
    .src(intf.master), .audio_out(audio_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk, n_fail;
  int m_st, m_lvl, m_acc, m_div, m_req, m_aout;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model advances on each edge using the inputs present at that edge.
  task automatic model_step();
    int  sv, a, nst, sum;
    bit  tick;
    if (rst) begin
      m_st = S_OFF; m_lvl = 0; m_acc = 0; m_div = 0; m_req = 0; m_aout = 0;
      return;
    end
    tick   = (m_div == DIV - 1);
    m_req  = (tick && m_st != S_OFF) ? 1 : 0;
    sum    = (m_acc % 65536) + m_lvl;
    m_acc  = sum;
    m_aout = sum / 65536;
    nst = m_st;
    case (m_st)
      S_OFF: if (enable) nst = S_UP;
      S_UP:  if (!enable) nst = S_DN; else if (m_lvl == 32768) nst = S_RUN;
      S_RUN: if (!enable) nst = S_DN;
      default: if (enable) nst = S_UP; else if (m_lvl == 0) nst = S_OFF;
    endcase
    if (tick) begin
      case (m_st)
        S_UP:  m_lvl = (m_lvl + STEP > 32768) ? 32768 : m_lvl + STEP;
        S_RUN: begin
          sv = int'({16'h0, intf.sample_in}) - 32768;
          a  = sv >>> volume;
          m_lvl = mute ? 32768 : a + 32768;
        end
        S_DN:  m_lvl = (m_lvl > STEP) ? m_lvl - STEP : 0;
        default: m_lvl = 0;
      endcase
    end
    m_st  = nst;
    m_div = tick ? 0 : m_div + 1;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    chk("audio_out", int'(audio_out), m_aout);
    chk("sample_req", int'(intf.sample_req), m_req);
    chk("busy", int'(busy), (m_st != S_OFF) ? 1 : 0);
    chk("level", int'(dut.level_q), m_lvl);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wait_state(input int st, input string tag);
    int k;
    k = 0;
    while (m_st != st && k < 400) begin cyc(); k++; end
    chk(tag, (m_st == st) ? 1 : 0, 1);
  endtask

  task automatic count_ones(input int n, output int ones, output int reqs);
    ones = 0; reqs = 0;
    for (int i = 0; i < n; i++) begin
      cyc();
      ones += int'(audio_out);
      reqs += int'(intf.sample_req);
    end
  endtask

  initial begin
    int ones, reqs, k;
    logic prev;
    n_chk = 0; n_fail = 0;
    m_st = S_OFF; m_lvl = 0; m_acc = 0; m_div = 0; m_req = 0; m_aout = 0;
    rst = 1'b1; enable = 1'b0; mute = 1'b0; volume = 3'd0;
    intf.sample_in = 16'h8000;

    // Reset and idle
    run(3);
    rst = 1'b0;
    count_ones(100, ones, reqs);
    chk("idle_ones", ones, 0);
    chk("idle_reqs", reqs, 0);

    // Ramp up to RUN; one request per divider period
    enable = 1'b1;
    cyc();
    chk("busy_after_en", int'(busy), 1);
    count_ones(32, ones, reqs);
    chk("ramp_reqs", reqs, 4);
    wait_state(S_RUN, "reach_run");

    // Density at 0xA000 and 0x4000
    intf.sample_in = 16'hC000; volume = 3'd1;
    run(2 * DIV);
    chk("level_a000", int'(dut.level_q), 'hA000);
    count_ones(64, ones, reqs);
    chk("density_a000", ones, 40);
    intf.sample_in = 16'h4000; volume = 3'd0;
    run(2 * DIV);
    count_ones(64, ones, reqs);
    chk("density_4000", ones, 16);

    // Volume 7 on full-scale, then mute -> midscale alternating stream
    intf.sample_in = 16'hFFFF; volume = 3'd7;
    run(2 * DIV);
    chk("level_80ff", int'(dut.level_q), 'h80FF);
    mute = 1'b1;
    run(2 * DIV);
    chk("level_mute", int'(dut.level_q), 'h8000);
    prev = audio_out;
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("mute_alt", int'(audio_out), int'(!prev));
      prev = audio_out;
    end
    mute = 1'b0;

    // Ramp reversal: drop enable at 0x6000, re-enable at 0x2000 on the way down
    rst = 1'b1; cyc(); rst = 1'b0;
    enable = 1'b1;
    k = 0;
    while (!(m_st == S_UP && m_lvl == 'h6000) && k < 400) begin cyc(); k++; end
    chk("reach_6000", int'(dut.level_q), 'h6000);
    enable = 1'b0;
    k = 0;
    while (!(m_st == S_DN && m_lvl == 'h2000) && k < 400) begin cyc(); k++; end
    chk("reach_2000", int'(dut.level_q), 'h2000);
    enable = 1'b1;
    k = 0;
    while (m_lvl == 'h2000 && k < 400) begin cyc(); k++; end
    chk("reenable_4000", int'(dut.level_q), 'h4000);
    enable = 1'b0;
    wait_state(S_OFF, "reach_off");
    count_ones(3 * DIV, ones, reqs);
    chk("off_reqs", reqs, 0);
    chk("off_busy", int'(busy), 0);

    // Randomized play
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      if ($urandom_range(0, 29) == 0) mute = ~mute;
      if ($urandom_range(0, 9) == 0) volume = 3'($urandom_range(0, 7));
      intf.sample_in = 16'($urandom);
      rst = ($urandom_range(0, 599) == 0);
      cyc();
    end
    rst = 1'b0; mute = 1'b0;

    // Reset in RUN one cycle ahead of a tick
    enable = 1'b1;
    wait_state(S_RUN, "reach_run2");
    k = 0;
    while (m_div != DIV - 2 && k < 2 * DIV) begin cyc(); k++; end
    rst = 1'b1;
    cyc();
    rst = 1'b0; enable = 1'b0;
    chk("rst_busy", int'(busy), 0);
    chk("rst_req", int'(intf.sample_req), 0);
    chk("rst_aout", int'(audio_out), 0);
    cyc();
    chk("rst_req_next", int'(intf.sample_req), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_sample_dac.md
Name: audio_sample_dac

Overview:
- Consumer end of the `sinewaver` / sample-source interface.
- Generates the periodic `sample_req` pulse that drives a source's `trigger` input, and latches the source's 16-bit offset-binary sample.
- Applies volume attenuation, mute, and click-free ramp-up/ramp-down.
- Converts the result to a 1-bit first-order sigma-delta stream for a speaker/RC-filter pin.

Parameters:
- DIV, 1250: clock cycles per sample period. Legal range 2..65535. 1250 gives a 20 kHz sample rate at 25 MHz.
- RAMP_STEP, 16'h0040: level change per sample tick during ramps. 512 ticks for 0 to 0x8000.

Ports:
- clk  input  1  system clock, rising edge active
- rst  input  1  system reset, active-high, synchronous
- enable  input  1  1 = play, 0 = ramp down and go idle
- mute  input  1  in RUN, force level to midscale 0x8000
- volume  input  3  attenuation: signed sample arithmetic-shifted right by this amount (0 = full scale)
- sample_in  input  16  source sample, offset binary, 0x8000 = silence
- sample_req  output  1  one-cycle pulse per sample period; connect to source `trigger`
- audio_out  output  1  sigma-delta bitstream
- busy  output  1  high in any state other than OFF

Behaviour:
- Reset (`rst` high at a clock edge) forces the following:
  - state=OFF, divider=0, level=16'h0000, acc=17'h0.
  - `sample_req`=0, `audio_out`=0, `busy`=0.
  - Reset mid-ramp or mid-RUN takes effect the same edge; no ramp-down.
- Divider:
  - Counts 0..DIV-1 and wraps; runs in every state.
  - `tick` is an internal signal: count==DIV-1.
  - `sample_req` is registered: high for exactly the one cycle after a cycle with `tick` && state!=OFF. It is therefore never high in OFF.
- Sample capture:
  - On a tick, `sample_in` is latched as presented that cycle. The source advances on the `sample_req` that follows, so the output is always one sample behind the source.
- Attenuation (combinational on the latched sample):
  - s = latched ^ 16'h8000, treated as signed.
  - a = s >>> volume, arithmetic.
  - att = a ^ 16'h8000.
  - `volume` is sampled at each tick, not mid-period.
- State machine: OFF, RAMP_UP, RUN, RAMP_DOWN. Transitions are evaluated every cycle; `level` changes only on tick edges.
  - OFF: level held at 0. `enable`=1 -> RAMP_UP next cycle.
  - RAMP_UP: on tick, level <= min(level+RAMP_STEP, 0x8000), computed in 17 bits with no wrap. When level==0x8000 -> RUN. `enable`=0 -> RAMP_DOWN from the current level.
  - RUN: on tick, level <= mute ? 0x8000 : att. `enable`=0 -> RAMP_DOWN.
  - RAMP_DOWN: on tick, level <= (level > RAMP_STEP) ? level-RAMP_STEP : 0. When level==0 -> OFF. `enable`=1 -> RAMP_UP from the current level.
  - A level above 0x8000 ramps down linearly to 0; no intermediate clamp to midscale.
  - If `enable` changes on the same cycle as a tick, the tick's level update uses the old state's rule, and the state changes that edge.
- Sigma-delta (every cycle, all states):
  - acc <= {1'b0, acc[15:0]} + {1'b0, level}.
  - `audio_out` <= acc[16] of the new sum, registered.
  - Density of ones = level/65536.
  - In OFF, level=0, so `audio_out` stays 0 once acc[15:0] has drained; this happens within one cycle, since adding 0 never carries.
- Latency:
  - `sample_in` captured on tick N affects `level` at the same edge.
  - It affects `audio_out` one cycle later.

Test Plan:
- Reset / idle: DIV=8, hold rst 3 cycles, then `enable`=0 for 100 cycles -> `audio_out`=0, `sample_req`=0, `busy`=0 throughout.
- Ramp up: DIV=8, RAMP_STEP=16'h2000, `enable`=1 from cycle 0 -> `busy`=1; level 0x2000, 0x4000, 0x6000, 0x8000 on 4 successive ticks, then RUN; `sample_req` pulses every 8 cycles.
- Density: in RUN, DIV=8, `sample_in`=16'hC000, `volume`=1 -> att=0xA000; `audio_out` duty over 64 cycles = 40 ones ±1. With `sample_in`=0x4000, `volume`=0 -> exactly 1 in every 4 cycles.
- Mute and volume: RUN, `sample_in`=16'hFFFF, `volume`=7 -> level 0x80FF. Raise `mute` -> level 0x8000 on the next tick; alternating 1/0 `audio_out`.
- Ramp reversal and shutdown:
  - RAMP_STEP=16'h2000: drop `enable` when level=0x6000 in RAMP_UP -> 0x4000, 0x2000, 0x0000, then OFF.
  - Re-assert `enable` at level 0x2000 in RAMP_DOWN -> next tick 0x4000.
  - In OFF, `busy`=0 and `sample_req` stops.
- Mid-run reset: assert `rst` in RUN one cycle before a tick -> next cycle all outputs 0 and state OFF; no `sample_req` emitted.
